// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and FSM state type for the framebuffer scanout reader.
//   ADDR_W     - Avalon word-address width
//   DATA_W     - SDRAM data / pixel stream width
//   BURSTCNT_W - Avalon burstcount width
package fb_pkg;

   localparam int ADDR_W     = 29;
   localparam int DATA_W     = 64;
   localparam int BURSTCNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      REQ   = 2'd2,
      DATA  = 2'd3
   } state_t;

endpackage

// File: rtl/fb_scanout_reader_if.sv
// fb_scanout_reader_if: bundles the Avalon-MM read-master signals toward the
// HPS f2h_sdram0 port and the valid/ready pixel stream toward the video stage.
//   master modport - the scanout reader (drives read requests and the stream)
//   slave  modport - the environment (SDRAM port and stream consumer)
interface fb_scanout_reader_if #(
   parameter int ADDR_W = 29
);
   import fb_pkg::*;

   logic [ADDR_W-1:0]     avm_address;
   logic [BURSTCNT_W-1:0] avm_burstcount;
   logic                  avm_read;
   logic                  avm_waitrequest;
   logic [DATA_W-1:0]     avm_readdata;
   logic                  avm_readdatavalid;

   logic [DATA_W-1:0]     pix_data;
   logic                  pix_valid;
   logic                  pix_ready;

   modport master (
      output avm_address, avm_burstcount, avm_read,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      output pix_data, pix_valid,
      input  pix_ready
   );

   modport slave (
      input  avm_address, avm_burstcount, avm_read,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  pix_data, pix_valid,
      output pix_ready
   );

endinterface

// File: rtl/fb_sync_fifo.sv
// fb_sync_fifo: single-clock FIFO with registered head outputs.
//   i_clk, i_rst_n      - clock, synchronous active-low reset (empties FIFO)
//   i_wr_en, i_wr_data  - push
//   i_rd_en             - pop when o_valid is high
//   o_data, o_valid     - registered head word / not-empty
//   o_count             - occupancy, used by the caller for free-space checks
module fb_sync_fifo #(
   parameter  int DEPTH = 64,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   logic             w_rd;
   logic             w_wr;
   logic [AW-1:0]    w_rd_ptr_nxt;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_rd         = i_rd_en && r_valid;
   // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
   assign w_wr         = i_wr_en && ((r_count != CNT_W'(DEPTH)) || w_rd);
   assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_rd);

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr && !w_rd) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (!w_wr && w_rd) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_valid  <= (w_count_nxt != '0);
         // The new head is the incoming word when it lands exactly in the next
         // read slot (FIFO empty, or draining its last word this cycle).
         r_data   <= (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) ? i_wr_data : r_mem[w_rd_ptr_nxt];
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_count = r_count;

endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: fetches one framebuffer from SDRAM with Avalon-MM burst
// reads and streams the 64-bit words to the display pipeline.
//   clk_clk, reset_reset_n - clock, synchronous active-low reset
//   start                  - pulse; begins a fetch when idle
//   base_addr, frame_words - frame start word address / length, latched on start
//   bus (master)           - Avalon read master + pixel valid/ready stream
//   busy, done             - fetch in progress / last word entered the FIFO
//
// state | meaning
// IDLE  | waiting for start; beats arriving here are dropped
// ISSUE | pick next burst length, wait for FIFO room, or finish the frame
// REQ   | read request on the bus, held while waitrequest is high
// DATA  | collecting the beats of the single outstanding burst
module fb_scanout_reader
   import fb_pkg::*;
#(
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_W     = 29
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [23:0]         frame_words,
   fb_scanout_reader_if.master bus,
   output logic                busy,
   output logic                done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t                r_state;
   logic [ADDR_W-1:0]     r_addr;
   logic [23:0]           r_remaining;
   logic [BURSTCNT_W-1:0] r_beats;
   logic                  r_avm_read;
   logic [ADDR_W-1:0]     r_avm_address;
   logic [BURSTCNT_W-1:0] r_avm_burstcount;
   logic                  r_busy;
   logic                  r_done;

   logic [BURSTCNT_W-1:0] w_len;
   logic [CNT_W-1:0]      w_count;
   logic [CNT_W-1:0]      w_free;
   logic                  w_fifo_wr;

   assign w_len     = (r_remaining < 24'(BURST_LEN)) ? r_remaining[BURSTCNT_W-1:0]
                                                     : BURSTCNT_W'(BURST_LEN);
   assign w_free    = CNT_W'(FIFO_DEPTH) - w_count;
   assign w_fifo_wr = (r_state == DATA) && bus.avm_readdatavalid;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_state          <= IDLE;
         r_addr           <= '0;
         r_remaining      <= '0;
         r_beats          <= '0;
         r_avm_read       <= 1'b0;
         r_avm_address    <= '0;
         r_avm_burstcount <= '0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // busy covers the done cycle itself, then drops
         if (r_done) begin
            r_busy <= 1'b0;
         end
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr      <= base_addr;
                  r_remaining <= frame_words;
                  r_busy      <= 1'b1;
                  if (frame_words == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (r_remaining == '0) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else if (32'(w_free) >= 32'(w_len)) begin
                  r_avm_read       <= 1'b1;
                  r_avm_address    <= r_addr;
                  r_avm_burstcount <= w_len;
                  r_state          <= REQ;
               end
            end
            REQ: begin
               if (!bus.avm_waitrequest) begin
                  r_avm_read  <= 1'b0;
                  r_addr      <= r_addr + ADDR_W'(r_avm_burstcount);
                  r_remaining <= r_remaining - 24'(r_avm_burstcount);
                  r_beats     <= r_avm_burstcount;
                  r_state     <= DATA;
               end
            end
            DATA: begin
               if (bus.avm_readdatavalid) begin
                  r_beats <= r_beats - BURSTCNT_W'(1);
                  if (r_beats == BURSTCNT_W'(1)) begin
                     r_state <= ISSUE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   fb_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .i_clk     (clk_clk),
      .i_rst_n   (reset_reset_n),
      .i_wr_en   (w_fifo_wr),
      .i_wr_data (bus.avm_readdata),
      .i_rd_en   (bus.pix_ready),
      .o_data    (bus.pix_data),
      .o_valid   (bus.pix_valid),
      .o_count   (w_count)
   );

   assign bus.avm_read       = r_avm_read;
   assign bus.avm_address    = r_avm_address;
   assign bus.avm_burstcount = r_avm_burstcount;
   assign busy               = r_busy;
   assign done               = r_done;

endmodule

// File: tb/tb_fb_scanout_reader.sv
`timescale 1ns/1ps
module tb_fb_scanout_reader;
   import fb_pkg::*;

   typedef struct packed {
      logic [28:0] addr;
      logic [7:0]  len;
   } burst_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [28:0] base_addr = '0;
   logic [23:0] frame_words = '0;
   logic        busy;
   logic        done;

   fb_scanout_reader_if #(.ADDR_W(29)) bus();

   fb_scanout_reader #(
      .BURST_LEN  (16),
      .FIFO_DEPTH (64),
      .ADDR_W     (29)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .start         (start),
      .base_addr     (base_addr),
      .frame_words   (frame_words),
      .bus           (bus),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int failures = 0;

   // SDRAM model state
   burst_t      pend_q[$];
   logic [28:0] acc_addr_q[$];
   int          acc_len_q[$];
   int          hold_q[$];
   bit          chg_q[$];
   int          first_obs_pop_q[$];
   int          req_idx = 0;
   int          stall_idx = -1;
   int          stall_n = 0;
   int          wait_left = 0;
   bit          req_seen = 0;
   logic [28:0] cur_addr;
   logic [7:0]  cur_len;
   int          hold = 0;
   bit          chg = 0;
   int          beat_in_burst = 0;
   int          beats_driven = 0;
   int          read_hi_cnt = 0;
   int          first_rdv_cyc = -1;

   // stream monitor state
   logic [63:0] pix_q[$];
   int          done_cnt = 0;
   int          first_pix_cyc = -1;
   int          pv_seen = 0;

   function automatic logic [63:0] word_of(input logic [28:0] a);
      return {3'b101, a, 3'b010, ~a};
   endfunction

   function automatic int bad_words(input logic [28:0] b, input int n);
      int bad = 0;
      if (pix_q.size() != n) bad++;
      for (int k = 0; k < n && k < pix_q.size(); k++)
         if (pix_q[k] !== word_of(b + 29'(k))) bad++;
      return bad;
   endfunction

   function automatic logic [28:0] acc_addr(input int i);
      return (i < acc_addr_q.size()) ? acc_addr_q[i] : '1;
   endfunction

   function automatic int acc_len(input int i);
      return (i < acc_len_q.size()) ? acc_len_q[i] : -1;
   endfunction

   // SDRAM port model: decides waitrequest/readdatavalid at the falling edge.
   // Data for a burst starts the falling edge after its acceptance.
   initial begin
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      forever begin
         @(negedge clk);
         bus.avm_readdatavalid = 1'b0;
         if (pend_q.size() > 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = word_of(pend_q[0].addr + 29'(beat_in_burst));
            if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
            beats_driven++;
            beat_in_burst++;
            if (beat_in_burst == int'(pend_q[0].len)) begin
               void'(pend_q.pop_front());
               beat_in_burst = 0;
            end
         end
         bus.avm_waitrequest = 1'b0;
         if (!rst_n) begin
            req_seen = 0;
         end else if (bus.avm_read) begin
            read_hi_cnt++;
            if (!req_seen) begin
               req_seen  = 1;
               cur_addr  = bus.avm_address;
               cur_len   = bus.avm_burstcount;
               hold      = 0;
               chg       = 0;
               wait_left = (req_idx == stall_idx) ? stall_n : 0;
               first_obs_pop_q.push_back(pix_q.size());
            end else if (bus.avm_address !== cur_addr || bus.avm_burstcount !== cur_len) begin
               chg = 1;
            end
            hold++;
            if (wait_left > 0) begin
               bus.avm_waitrequest = 1'b1;
               wait_left--;
            end else begin
               acc_addr_q.push_back(cur_addr);
               acc_len_q.push_back(int'(cur_len));
               hold_q.push_back(hold);
               chg_q.push_back(chg);
               pend_q.push_back('{addr: cur_addr, len: cur_len});
               req_idx++;
               req_seen = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.pix_valid && bus.pix_ready) pix_q.push_back(bus.pix_data);
         if (bus.pix_valid) begin
            pv_seen++;
            if (first_pix_cyc < 0) first_pix_cyc = cyc;
         end
         if (done) done_cnt++;
      end
   end

   task automatic clear_logs();
      acc_addr_q.delete();
      acc_len_q.delete();
      hold_q.delete();
      chg_q.delete();
      first_obs_pop_q.delete();
      pix_q.delete();
      req_idx       = 0;
      stall_idx     = -1;
      stall_n       = 0;
      read_hi_cnt   = 0;
      done_cnt      = 0;
      first_rdv_cyc = -1;
      first_pix_cyc = -1;
   endtask

   task automatic start_frame(input logic [28:0] b, input logic [23:0] n);
      @(posedge clk); #1;
      base_addr   = b;
      frame_words = n;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int nwords);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done_cnt >= 1 && pix_q.size() >= nwords) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wait_done timeout: done_cnt=%0d words=%0d, required done and %0d words",
                  done_cnt, pix_q.size(), nwords);
      end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.avm_read !== 1'b0) begin failures++; $display("FAIL reset_read: got %b want 0", bus.avm_read); end
      checks++; if (bus.avm_address !== 29'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", bus.avm_address); end
      checks++; if (bus.avm_burstcount !== 8'h0) begin failures++; $display("FAIL reset_bc: got %h want 0", bus.avm_burstcount); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid: got %b want 0", bus.pix_valid); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic();
      int bad;
      clear_logs();
      bus.pix_ready = 1'b1;
      start_frame(29'h100, 24'd40);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start: got %b want 1", busy); end
      wait_done(600, 40);
      checks++; if (acc_addr_q.size() != 3) begin failures++; $display("FAIL basic_nbursts: got %0d want 3", acc_addr_q.size()); end
      checks++; if (acc_addr(0) !== 29'h100 || acc_len(0) != 16) begin failures++; $display("FAIL basic_burst0: got %h/%0d want 100/16", acc_addr(0), acc_len(0)); end
      checks++; if (acc_addr(1) !== 29'h110 || acc_len(1) != 16) begin failures++; $display("FAIL basic_burst1: got %h/%0d want 110/16", acc_addr(1), acc_len(1)); end
      checks++; if (acc_addr(2) !== 29'h120 || acc_len(2) != 8) begin failures++; $display("FAIL basic_burst2: got %h/%0d want 120/8", acc_addr(2), acc_len(2)); end
      bad = bad_words(29'h100, 40);
      checks++; if (bad != 0) begin failures++; $display("FAIL basic_words: %0d bad of %0d received, want 0 bad of 40", bad, pix_q.size()); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
      checks++; if (first_pix_cyc - first_rdv_cyc != 1) begin failures++; $display("FAIL basic_latency: got %0d want 1", first_pix_cyc - first_rdv_cyc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_stall();
      int bad;
      clear_logs();
      stall_idx = 1;
      stall_n   = 5;
      bus.pix_ready = 1'b1;
      start_frame(29'h200, 24'd40);
      wait_done(600, 40);
      checks++; if (acc_addr_q.size() != 3) begin failures++; $display("FAIL stall_nbursts: got %0d want 3", acc_addr_q.size()); end
      checks++; if (acc_addr(1) !== 29'h210 || acc_len(1) != 16) begin failures++; $display("FAIL stall_burst1: got %h/%0d want 210/16", acc_addr(1), acc_len(1)); end
      checks++; if (hold_q.size() < 2 || hold_q[1] != 6) begin failures++; $display("FAIL stall_hold_cycles: got %0d want 6", (hold_q.size() > 1) ? hold_q[1] : -1); end
      checks++; if (chg_q.size() < 2 || chg_q[1] !== 1'b0) begin failures++; $display("FAIL stall_stable: got changed=%0d want 0", (chg_q.size() > 1) ? int'(chg_q[1]) : -1); end
      checks++; if (hold_q.size() < 1 || hold_q[0] != 1) begin failures++; $display("FAIL stall_burst0_hold: got %0d want 1", (hold_q.size() > 0) ? hold_q[0] : -1); end
      bad = bad_words(29'h200, 40);
      checks++; if (bad != 0) begin failures++; $display("FAIL stall_words: %0d bad, want 0", bad); end
   endtask

   task automatic test_backpressure();
      int bad;
      int abad;
      clear_logs();
      bus.pix_ready = 1'b0;
      start_frame(29'h400, 24'd128);
      repeat (300) @(posedge clk);
      #1;
      checks++; if (acc_addr_q.size() != 4) begin failures++; $display("FAIL bp_bursts_while_blocked: got %0d want 4", acc_addr_q.size()); end
      checks++; if (bus.avm_read !== 1'b0) begin failures++; $display("FAIL bp_read_idle: got %b want 0", bus.avm_read); end
      checks++; if (done_cnt != 0 || busy !== 1'b1) begin failures++; $display("FAIL bp_in_progress: got done_cnt=%0d busy=%b want 0/1", done_cnt, busy); end
      bus.pix_ready = 1'b1;
      wait_done(2000, 128);
      checks++; if (acc_addr_q.size() != 8) begin failures++; $display("FAIL bp_nbursts: got %0d want 8", acc_addr_q.size()); end
      abad = 0;
      for (int i = 0; i < 8; i++)
         if (acc_addr(i) !== 29'h400 + 29'(16 * i) || acc_len(i) != 16) abad++;
      checks++; if (abad != 0) begin failures++; $display("FAIL bp_burst_addrs: %0d bad, want 0", abad); end
      checks++; if (first_obs_pop_q.size() < 5 || first_obs_pop_q[4] < 16 || first_obs_pop_q[4] > 18) begin
         failures++; $display("FAIL bp_reissue_space: got popped=%0d want 16..18", (first_obs_pop_q.size() > 4) ? first_obs_pop_q[4] : -1);
      end
      bad = bad_words(29'h400, 128);
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_words: %0d bad of %0d, want 0 bad of 128", bad, pix_q.size()); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_edge_lengths();
      int bad;
      clear_logs();
      bus.pix_ready = 1'b1;
      start_frame(29'h40, 24'd0);
      checks++; if (done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL zero_done_next: got done=%b busy=%b want 1/1", done, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_done_single: got done=%b busy=%b want 0/0", done, busy); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if (read_hi_cnt != 0) begin failures++; $display("FAIL zero_no_read: got %0d read cycles want 0", read_hi_cnt); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end

      clear_logs();
      start_frame(29'h55, 24'd1);
      wait_done(200, 1);
      checks++; if (acc_addr_q.size() != 1 || acc_addr(0) !== 29'h55 || acc_len(0) != 1) begin
         failures++; $display("FAIL one_burst: got n=%0d %h/%0d want 1 55/1", acc_addr_q.size(), acc_addr(0), acc_len(0));
      end
      bad = bad_words(29'h55, 1);
      checks++; if (bad != 0) begin failures++; $display("FAIL one_word: %0d bad, want 0", bad); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL one_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_mid_burst();
      int b0;
      int pv0;
      bit ok = 0;
      clear_logs();
      bus.pix_ready = 1'b1;
      b0 = beats_driven;
      start_frame(29'h800, 24'd32);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (beats_driven - b0 >= 3) begin
            ok = 1;
            break;
         end
      end
      checks++; if (!ok) begin failures++; $display("FAIL rst_mid_no_beats: got %0d beats want 3", beats_driven - b0); end
      checks++; if (bus.avm_address !== 29'h800) begin failures++; $display("FAIL rst_mid_pre_addr: got %h want 800", bus.avm_address); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.avm_read !== 1'b0 || bus.avm_address !== 29'h0 || bus.avm_burstcount !== 8'h0) begin
         failures++; $display("FAIL rst_mid_bus: got read=%b addr=%h bc=%h want 0/0/0", bus.avm_read, bus.avm_address, bus.avm_burstcount);
      end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_status: got busy=%b done=%b want 0/0", busy, done); end
      checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_pix_valid: got %b want 0", bus.pix_valid); end
      rst_n = 1'b1;
      pv0 = pv_seen;
      repeat (30) @(posedge clk);
      #1;
      checks++; if (pv_seen != pv0) begin failures++; $display("FAIL rst_mid_late_beats: got %0d valid cycles want 0", pv_seen - pv0); end
      checks++; if (acc_addr_q.size() != 1 || done_cnt != 0) begin failures++; $display("FAIL rst_mid_quiet: got bursts=%0d done=%0d want 1/0", acc_addr_q.size(), done_cnt); end
   endtask

   task automatic test_wrap();
      int bad;
      clear_logs();
      bus.pix_ready = 1'b1;
      start_frame(29'h1FFFFFF0, 24'd24);
      wait_done(400, 24);
      checks++; if (acc_addr_q.size() != 2) begin failures++; $display("FAIL wrap_nbursts: got %0d want 2", acc_addr_q.size()); end
      checks++; if (acc_addr(0) !== 29'h1FFFFFF0 || acc_len(0) != 16) begin failures++; $display("FAIL wrap_burst0: got %h/%0d want 1ffffff0/16", acc_addr(0), acc_len(0)); end
      checks++; if (acc_addr(1) !== 29'h0 || acc_len(1) != 8) begin failures++; $display("FAIL wrap_burst1: got %h/%0d want 0/8", acc_addr(1), acc_len(1)); end
      bad = bad_words(29'h1FFFFFF0, 24);
      checks++; if (bad != 0) begin failures++; $display("FAIL wrap_words: %0d bad, want 0", bad); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL wrap_done_pulses: got %0d want 1", done_cnt); end
   endtask

   initial begin
      bus.pix_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_backpressure();
      test_edge_lengths();
      test_reset_mid_burst();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
